// File: rtl/exec_unit_p.sv
// Clocked execute stage: GPR file, special GPR, ALU, registered flags and an
// iterative shift-add multiplier behind a valid/ready instruction handshake.
module exec_unit_p #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              illegal,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] sgpr,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_e;
  typedef enum logic [4:0] {
    OP_MOVSGPR = 5'd0, OP_MOV, OP_ADD, OP_SUB, OP_MUL, OP_OR,
    OP_AND, OP_XOR, OP_XNOR, OP_NAND, OP_NOR, OP_NOT
  } op_e;

  state_e              state_q;
  logic                ready_q, res_valid_q, illegal_q;
  logic [31:0]         ir_q;
  logic [DATA_W-1:0]   gpr_q [NREG];
  logic [DATA_W-1:0]   sgpr_q, res_data_q;
  logic [3:0]          flags_q;
  logic [2*DATA_W-1:0] mcand_q, acc_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CW-1:0]       cnt_q;

  logic [4:0]          ir_op, ir_rd, ir_rs1, ir_rs2;
  logic                ir_imm, op_ill;
  logic [DATA_W-1:0]   op_a, op_b, alu_res;
  logic                alu_c, alu_o;
  logic [DATA_W:0]     sum_w, diff_w;
  logic [2*DATA_W-1:0] mul_step;

  assign ir_op  = ir_q[31:27];
  assign ir_rd  = ir_q[26:22];
  assign ir_rs1 = ir_q[21:17];
  assign ir_imm = ir_q[16];
  assign ir_rs2 = ir_q[15:11];
  assign op_ill = (ir_op > OP_NOT);

  always_comb begin
    op_a = '0;
    if ({27'd0, ir_rs1} < NREG) op_a = gpr_q[ir_rs1];
    op_b = '0;
    if (ir_imm) op_b = DATA_W'(ir_q[15:0]);
    else if ({27'd0, ir_rs2} < NREG) op_b = gpr_q[ir_rs2];

    sum_w  = {1'b0, op_a} + {1'b0, op_b};
    diff_w = {1'b0, op_a} - {1'b0, op_b};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (op_e'(ir_op))
      OP_MOVSGPR: alu_res = sgpr_q;
      OP_MOV:     alu_res = ir_imm ? op_b : op_a;
      OP_ADD: begin
        alu_res = sum_w[DATA_W-1:0];
        alu_c   = sum_w[DATA_W];
        alu_o   = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_SUB: begin
        alu_res = diff_w[DATA_W-1:0];
        alu_c   = diff_w[DATA_W];
        alu_o   = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (alu_res[DATA_W-1] != op_a[DATA_W-1]);
      end
      OP_OR:      alu_res = op_a | op_b;
      OP_AND:     alu_res = op_a & op_b;
      OP_XOR:     alu_res = op_a ^ op_b;
      OP_XNOR:    alu_res = ~(op_a ^ op_b);
      OP_NAND:    alu_res = ~(op_a & op_b);
      OP_NOR:     alu_res = ~(op_a | op_b);
      OP_NOT:     alu_res = ir_imm ? ~op_b : ~op_a;
      default:    alu_res = '0;
    endcase

    mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign instr_ready = ready_q;
  assign res_valid   = res_valid_q;
  assign illegal     = illegal_q;
  assign res_data    = res_data_q;
  assign flags       = flags_q;
  assign sgpr        = sgpr_q;
  assign dbg_data    = ({27'd0, dbg_addr} < NREG) ? gpr_q[dbg_addr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      ir_q        <= '0;
      sgpr_q      <= '0;
      res_data_q  <= '0;
      flags_q     <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      for (int unsigned i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else begin
      res_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (instr_valid && ready_q) begin
            ir_q    <= instr;
            ready_q <= 1'b0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (op_ill) begin
            res_valid_q <= 1'b1;
            illegal_q   <= 1'b1;
            res_data_q  <= '0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end else if (ir_op == OP_MUL) begin
            mcand_q  <= {{DATA_W{1'b0}}, op_a};
            mplier_q <= op_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= MUL;
          end else begin
            if ({27'd0, ir_rd} < NREG) gpr_q[ir_rd] <= alu_res;
            flags_q     <= {alu_res[DATA_W-1], alu_res == '0, alu_o, alu_c};
            res_data_q  <= alu_res;
            res_valid_q <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        MUL: begin
          acc_q    <= mul_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          // Last partial product is folded in combinationally so retire lands on the final MUL edge.
          if (cnt_q == CW'(DATA_W - 1)) begin
            if ({27'd0, ir_rd} < NREG) gpr_q[ir_rd] <= mul_step[DATA_W-1:0];
            sgpr_q      <= mul_step[2*DATA_W-1:DATA_W];
            flags_q     <= {mul_step[2*DATA_W-1], mul_step == '0, 2'b00};
            res_data_q  <= mul_step[DATA_W-1:0];
            res_valid_q <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_p.sv
// Directed self-checking bench for exec_unit_p (DATA_W=16, NREG=32).
module tb_exec_unit_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        res_valid;
  logic [15:0] res_data;
  logic        illegal;
  logic [3:0]  flags;
  logic [15:0] sgpr;
  logic [4:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;

  exec_unit_p #(.DATA_W(16), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .res_valid(res_valid), .res_data(res_data), .illegal(illegal),
    .flags(flags), .sgpr(sgpr), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ri(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 1'b1, imm};
  endfunction

  function automatic logic [31:0] rr(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, 1'b0, rs2, 11'd0};
  endfunction

  // Issues one instruction and measures edges from accept to res_valid (-1 on timeout).
  task automatic run(input logic [31:0] ins, output int lat, output int wt,
                     output logic [15:0] rdata, output logic ill, output logic rdy_busy);
    wt = 0;
    while (!instr_ready && wt < 50) begin @(posedge clk); #1; wt++; end
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = '0;
    lat = 0;
    rdy_busy = 1'b0;
    while (!res_valid && lat < 40) begin
      if (instr_ready) rdy_busy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (!res_valid) lat = -1;
    rdata = res_data;
    ill = illegal;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%b exp=0", instr_ready); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    n_cmp++; if (flags !== 4'h0 || sgpr !== 16'h0) begin n_err++; $display("FAIL rst_flags_sgpr got=%h/%h exp=0/0", flags, sgpr); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_before_edge got=%b exp=0", instr_ready); end
    @(posedge clk); #1;
    n_cmp++; if (instr_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_after_edge got=%b exp=1", instr_ready); end
  endtask

  task automatic test_add_overflow;
    int lat, wt; logic [15:0] d; logic il, rb;
    run(ri(5'd1, 5'd1, 5'd0, 16'h7FFF), lat, wt, d, il, rb);
    n_cmp++; if (lat !== 1 || d !== 16'h7FFF) begin n_err++; $display("FAIL mov_7fff got lat=%0d d=%h exp lat=1 d=7fff", lat, d); end
    run(ri(5'd2, 5'd2, 5'd1, 16'h0001), lat, wt, d, il, rb);
    n_cmp++; if (lat !== 1 || d !== 16'h8000) begin n_err++; $display("FAIL add_ovf got lat=%0d d=%h exp lat=1 d=8000", lat, d); end
    n_cmp++; if (flags !== 4'b1010) begin n_err++; $display("FAIL add_ovf_flags got=%b exp=1010", flags); end
    dbg_addr = 5'd2; #1;
    n_cmp++; if (dbg_data !== 16'h8000) begin n_err++; $display("FAIL dbg_r2 got=%h exp=8000", dbg_data); end
  endtask

  task automatic test_carry_borrow;
    int lat, wt; logic [15:0] d; logic il, rb;
    run(ri(5'd1, 5'd1, 5'd0, 16'hFFFF), lat, wt, d, il, rb);
    run(ri(5'd2, 5'd3, 5'd1, 16'h0001), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'h0000 || flags !== 4'b0101) begin n_err++; $display("FAIL add_carry got d=%h f=%b exp d=0000 f=0101", d, flags); end
    run(ri(5'd3, 5'd4, 5'd3, 16'h0001), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'hFFFF || flags !== 4'b1001) begin n_err++; $display("FAIL sub_borrow got d=%h f=%b exp d=ffff f=1001", d, flags); end
  endtask

  task automatic test_mul;
    int lat, wt; logic [15:0] d; logic il, rb;
    run(ri(5'd1, 5'd1, 5'd0, 16'h1234), lat, wt, d, il, rb);
    run(ri(5'd4, 5'd2, 5'd1, 16'h0100), lat, wt, d, il, rb);
    n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL mul_latency got=%0d exp=17", lat); end
    n_cmp++; if (d !== 16'h3400 || sgpr !== 16'h0012) begin n_err++; $display("FAIL mul_result got lo=%h hi=%h exp lo=3400 hi=0012", d, sgpr); end
    n_cmp++; if (rb !== 1'b0) begin n_err++; $display("FAIL mul_ready_low got=%b exp=0", rb); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL mul_flags got=%b exp=0000", flags); end
    run(ri(5'd0, 5'd5, 5'd0, 16'h0000), lat, wt, d, il, rb);
    dbg_addr = 5'd5; #1;
    n_cmp++; if (d !== 16'h0012 || dbg_data !== 16'h0012) begin n_err++; $display("FAIL movsgpr got d=%h r5=%h exp 0012", d, dbg_data); end
  endtask

  task automatic test_logic;
    int lat, wt; logic [15:0] d; logic il, rb;
    run(ri(5'd1, 5'd1, 5'd0, 16'h00F0), lat, wt, d, il, rb);
    run(ri(5'd1, 5'd2, 5'd0, 16'h0F00), lat, wt, d, il, rb);
    run(rr(5'd10, 5'd3, 5'd1, 5'd2), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'hF00F) begin n_err++; $display("FAIL nor got=%h exp=f00f", d); end
    run(rr(5'd8, 5'd3, 5'd1, 5'd2), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'hF00F) begin n_err++; $display("FAIL xnor got=%h exp=f00f", d); end
    run(rr(5'd9, 5'd3, 5'd1, 5'd2), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'hFFFF || flags !== 4'b1000) begin n_err++; $display("FAIL nand got d=%h f=%b exp d=ffff f=1000", d, flags); end
    run(rr(5'd6, 5'd3, 5'd1, 5'd2), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'h0000 || flags !== 4'b0100) begin n_err++; $display("FAIL and got d=%h f=%b exp d=0000 f=0100", d, flags); end
    run(rr(5'd5, 5'd3, 5'd1, 5'd2), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'h0FF0) begin n_err++; $display("FAIL or got=%h exp=0ff0", d); end
    run(rr(5'd7, 5'd3, 5'd1, 5'd2), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'h0FF0) begin n_err++; $display("FAIL xor got=%h exp=0ff0", d); end
    run(rr(5'd11, 5'd6, 5'd1, 5'd0), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'hFF0F) begin n_err++; $display("FAIL not_reg got=%h exp=ff0f", d); end
    run(ri(5'd11, 5'd6, 5'd1, 16'h00FF), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'hFF00) begin n_err++; $display("FAIL not_imm got=%h exp=ff00", d); end
    run(rr(5'd2, 5'd7, 5'd1, 5'd1), lat, wt, d, il, rb);
    n_cmp++; if (d !== 16'h01E0) begin n_err++; $display("FAIL add_same_src got=%h exp=01e0", d); end
    run(rr(5'd2, 5'd1, 5'd1, 5'd1), lat, wt, d, il, rb);
    dbg_addr = 5'd1; #1;
    n_cmp++; if (dbg_data !== 16'h01E0) begin n_err++; $display("FAIL add_rdst_eq_src got=%h exp=01e0", dbg_data); end
  endtask

  task automatic test_illegal;
    int lat, wt; logic [15:0] d; logic il, rb;
    run(ri(5'd3, 5'd7, 5'd0, 16'h0001), lat, wt, d, il, rb);
    run(ri(5'd31, 5'd1, 5'd0, 16'h5555), lat, wt, d, il, rb);
    n_cmp++; if (lat !== 1 || il !== 1'b1 || d !== 16'h0000) begin n_err++; $display("FAIL illegal got lat=%0d ill=%b d=%h exp 1/1/0000", lat, il, d); end
    dbg_addr = 5'd1; #1;
    n_cmp++; if (dbg_data !== 16'h01E0 || flags !== 4'b1001 || sgpr !== 16'h0012) begin
      n_err++; $display("FAIL illegal_state got r1=%h f=%b s=%h exp 01e0/1001/0012", dbg_data, flags, sgpr);
    end
    run(ri(5'd1, 5'd8, 5'd0, 16'hA5A5), lat, wt, d, il, rb);
    n_cmp++; if (wt !== 0 || lat !== 1 || il !== 1'b0 || d !== 16'hA5A5) begin
      n_err++; $display("FAIL back_to_back got wt=%0d lat=%0d ill=%b d=%h exp 0/1/0/a5a5", wt, lat, il, d);
    end
  endtask

  task automatic test_reset_mid_mul;
    int lat, wt; logic [15:0] d; logic il, rb;
    logic seen;
    instr = ri(5'd4, 5'd2, 5'd1, 16'h0003);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    dbg_addr = 5'd1; #1;
    n_cmp++; if (dbg_data !== 16'h0 || sgpr !== 16'h0 || flags !== 4'h0 || instr_ready !== 1'b0) begin
      n_err++; $display("FAIL midmul_reset got r1=%h s=%h f=%b rdy=%b exp 0/0/0/0", dbg_data, sgpr, flags, instr_ready);
    end
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (res_valid) seen = 1'b1; end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++; if (instr_ready !== 1'b0) begin n_err++; $display("FAIL midmul_ready_held got=%b exp=0", instr_ready); end
    repeat (20) begin @(posedge clk); #1; if (res_valid) seen = 1'b1; end
    dbg_addr = 5'd2; #1;
    n_cmp++; if (seen !== 1'b0 || dbg_data !== 16'h0) begin n_err++; $display("FAIL midmul_no_write got rv=%b r2=%h exp 0/0000", seen, dbg_data); end
    run(ri(5'd1, 5'd9, 5'd0, 16'h0042), lat, wt, d, il, rb);
    n_cmp++; if (lat !== 1 || d !== 16'h0042) begin n_err++; $display("FAIL post_reset_mov got lat=%0d d=%h exp 1/0042", lat, d); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_carry_borrow();
    test_mul();
    test_logic();
    test_illegal();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
